// File: rtl/dsram_responder_if.sv
// ----------------------------------------------------------------------------
// dsram_responder_if
//   Data SRAM request/response bundle between the CPU core MEM stage (master)
//   and the memory responder (slave).
//
//   data_sram_en     master->slave  1   access request this cycle
//   data_sram_wen    master->slave  4   byte write enables (0 with en=1 is a read)
//   data_sram_addr   master->slave  32  byte address, bits [1:0] ignored by RAM
//   data_sram_wdata  master->slave  32  write data, lane i = bits [8i+7:8i]
//   data_sram_rdata  slave->master  32  registered read data (1-cycle latency)
// ----------------------------------------------------------------------------
interface dsram_responder_if;
   logic        data_sram_en;
   logic [3:0]  data_sram_wen;
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;
   logic [31:0] data_sram_rdata;

   modport master (
      output data_sram_en,
      output data_sram_wen,
      output data_sram_addr,
      output data_sram_wdata,
      input  data_sram_rdata
   );

   modport slave (
      input  data_sram_en,
      input  data_sram_wen,
      input  data_sram_addr,
      input  data_sram_wdata,
      output data_sram_rdata
   );
endinterface

// File: rtl/dsram_responder.sv
// ----------------------------------------------------------------------------
// dsram_responder
//   Responder end of the core's data SRAM interface. Holds a byte-writable
//   word RAM of 2^ADDR_W 32-bit words plus a small register window at
//   MMIO_BASE (LED, switches, free-running timer, scratch). Read data is
//   registered and returned one cycle after the request edge.
//
//   clk        in   1   clock, all state on rising edge
//   rst        in   1   asynchronous active-low reset
//   bus        slave modport of dsram_responder_if (en/wen/addr/wdata/rdata)
//   switch_in  in   8   asynchronous board switches (2-flop synchronised)
//   led_out    out  16  LED register value
//
//   Register window (offset = addr[15:0]):
//     0x0000 LED      RW  {16'b0, led}
//     0x0004 SWITCH   RO  {24'b0, sw_sync}
//     0x0008 TIMER    RW  free-running 32-bit counter
//     0x000C SCRATCH  RW  32-bit
//     others          reads 0, writes ignored
//   Register writes require wen == 4'b1111; partial writes are dropped.
// ----------------------------------------------------------------------------
module dsram_responder #(
   parameter int unsigned ADDR_W    = 12,
   parameter logic [31:0] MMIO_BASE = 32'hBFAF_0000
) (
   input  logic                  clk,
   input  logic                  rst,
   dsram_responder_if.slave      bus,
   input  logic [7:0]            switch_in,
   output logic [15:0]           led_out
);

   localparam int unsigned RAM_WORDS = 1 << ADDR_W;

   typedef enum logic [2:0] {
      REG_LED,
      REG_SWITCH,
      REG_TIMER,
      REG_SCRATCH,
      REG_NONE
   } reg_sel_t;

   // ------------------------------------------------------------------------
   // Storage
   // ------------------------------------------------------------------------
   logic [31:0]       mem [RAM_WORDS];
   logic [31:0]       timer;
   logic [31:0]       timer_next;
   logic [31:0]       scratch;
   logic [7:0]        sw_meta;
   logic [7:0]        sw_sync;

   // ------------------------------------------------------------------------
   // Request decode
   // ------------------------------------------------------------------------
   logic              rd_req;
   logic              wr_req;
   logic              is_mmio;
   logic              ram_wr;
   logic              mmio_wr;
   logic [ADDR_W-1:0] ram_idx;
   reg_sel_t          reg_sel;
   logic [31:0]       wr_mask;
   logic [31:0]       rd_mux;

   always_comb begin
      rd_req  = bus.data_sram_en && (bus.data_sram_wen == 4'b0000);
      wr_req  = bus.data_sram_en && (bus.data_sram_wen != 4'b0000);
      is_mmio = (bus.data_sram_addr[31:16] == MMIO_BASE[31:16]);
      // Upper address bits are dropped, so the RAM aliases every 2^(ADDR_W+2) bytes.
      ram_idx = bus.data_sram_addr[ADDR_W+1:2];
      ram_wr  = wr_req && !is_mmio;
      mmio_wr = wr_req && is_mmio && (bus.data_sram_wen == 4'b1111);

      case (bus.data_sram_addr[15:0])
         16'h0000: reg_sel = REG_LED;
         16'h0004: reg_sel = REG_SWITCH;
         16'h0008: reg_sel = REG_TIMER;
         16'h000C: reg_sel = REG_SCRATCH;
         default:  reg_sel = REG_NONE;
      endcase

      wr_mask = {{8{bus.data_sram_wen[3]}}, {8{bus.data_sram_wen[2]}},
                 {8{bus.data_sram_wen[1]}}, {8{bus.data_sram_wen[0]}}};
   end

   // A timer write overrides that cycle's increment.
   always_comb begin
      if (mmio_wr && (reg_sel == REG_TIMER)) begin
         timer_next = bus.data_sram_wdata;
      end else begin
         timer_next = timer + 32'd1;
      end
   end

   // ------------------------------------------------------------------------
   // Read mux
   // ------------------------------------------------------------------------
   always_comb begin
      rd_mux = '0;
      if (is_mmio) begin
         case (reg_sel)
            REG_LED:     rd_mux = {16'h0000, led_out};
            REG_SWITCH:  rd_mux = {24'h000000, sw_sync};
            // The timer read returns the value the counter takes at the
            // sampling edge; reads never coincide with writes, so this is
            // always the incremented count.
            REG_TIMER:   rd_mux = timer + 32'd1;
            REG_SCRATCH: rd_mux = scratch;
            default:     rd_mux = '0;
         endcase
      end else begin
         rd_mux = mem[ram_idx];
      end
   end

   // ------------------------------------------------------------------------
   // Backing RAM (not reset). Writes are gated by rst so a request sampled
   // while reset is held is dropped like every other access.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst && ram_wr) begin
         mem[ram_idx] <= (mem[ram_idx] & ~wr_mask) | (bus.data_sram_wdata & wr_mask);
      end
   end

   // ------------------------------------------------------------------------
   // Registers, synchroniser, timer and read-data register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.data_sram_rdata <= '0;
         led_out             <= '0;
         timer               <= '0;
         scratch             <= '0;
         sw_meta             <= '0;
         sw_sync             <= '0;
      end else begin
         sw_meta <= switch_in;
         sw_sync <= sw_meta;
         timer   <= timer_next;

         if (mmio_wr) begin
            case (reg_sel)
               REG_LED:     led_out <= bus.data_sram_wdata[15:0];
               REG_SCRATCH: scratch <= bus.data_sram_wdata;
               default:     ;
            endcase
         end

         // rdata holds on idle and write cycles.
         if (rd_req) begin
            bus.data_sram_rdata <= rd_mux;
         end
      end
   end

endmodule

// File: tb/tb_dsram_responder.sv
// ----------------------------------------------------------------------------
// tb_dsram_responder
//   Directed, self-checking bench for dsram_responder. Inputs change on the
//   falling edge; outputs are checked on the following falling edge.
// ----------------------------------------------------------------------------
module tb_dsram_responder;

   localparam logic [31:0] BASE = 32'hBFAF_0000;

   logic        clk;
   logic        rst;
   logic [7:0]  switch_in;
   logic [15:0] led_out;

   int unsigned n_cmp;
   int unsigned n_bad;

   dsram_responder_if bus ();

   dsram_responder #(
      .ADDR_W    (12),
      .MMIO_BASE (BASE)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus.slave),
      .switch_in (switch_in),
      .led_out   (led_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "simulation timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive one request at the current falling edge, then advance to the next
   // falling edge so the posedge in between has sampled it.
   task automatic step(input logic en, input logic [3:0] wen,
                       input logic [31:0] addr, input logic [31:0] wdata);
      bus.data_sram_en    = en;
      bus.data_sram_wen   = wen;
      bus.data_sram_addr  = addr;
      bus.data_sram_wdata = wdata;
      @(negedge clk);
   endtask

   task automatic wr(input logic [31:0] addr, input logic [3:0] wen, input logic [31:0] wdata);
      step(1'b1, wen, addr, wdata);
   endtask

   task automatic rd(input logic [31:0] addr);
      step(1'b1, 4'b0000, addr, 32'h0);
   endtask

   task automatic idle();
      step(1'b0, 4'b0000, 32'h0, 32'h0);
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst = 1'b0;
      switch_in = 8'h00;
      bus.data_sram_en    = 1'b0;
      bus.data_sram_wen   = 4'b0000;
      bus.data_sram_addr  = '0;
      bus.data_sram_wdata = '0;

      #1;
      check("reset_rdata", bus.data_sram_rdata, 32'h0);
      check("reset_led", {16'h0, led_out}, 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;

      // Full-word RAM write and read-back, then hold behaviour.
      wr(32'h0000_0010, 4'hF, 32'hDEAD_BEEF);
      rd(32'h0000_0010);
      check("ram_word", bus.data_sram_rdata, 32'hDEAD_BEEF);
      idle();
      check("hold_idle", bus.data_sram_rdata, 32'hDEAD_BEEF);

      // Byte lanes 0 and 2 only.
      wr(32'h0000_0010, 4'b0101, 32'h1122_3344);
      check("hold_write", bus.data_sram_rdata, 32'hDEAD_BEEF);
      rd(32'h0000_0010);
      check("ram_bytes", bus.data_sram_rdata, 32'hDE22_BE44);

      // Aliasing modulo 16 KiB.
      wr(32'h0000_4010, 4'hF, 32'hA5A5_A5A5);
      rd(32'h0000_0010);
      check("ram_alias", bus.data_sram_rdata, 32'hA5A5_A5A5);

      // Timer load, back-to-back reads across the wrap.
      wr(BASE + 32'h8, 4'hF, 32'hFFFF_FFFE);
      rd(BASE + 32'h8);
      check("timer_load", bus.data_sram_rdata, 32'hFFFF_FFFF);
      rd(BASE + 32'h8);
      check("timer_wrap", bus.data_sram_rdata, 32'h0000_0000);

      // LED register.
      wr(BASE, 4'hF, 32'h0001_ABCD);
      check("led_write", {16'h0, led_out}, 32'h0000_ABCD);
      rd(BASE);
      check("led_read", bus.data_sram_rdata, 32'h0000_ABCD);
      wr(BASE, 4'b0011, 32'h0000_1234);
      check("led_partial", {16'h0, led_out}, 32'h0000_ABCD);

      // Unmapped offset reads zero.
      rd(BASE + 32'h10);
      check("unmapped", bus.data_sram_rdata, 32'h0);

      // Scratch, including a dropped partial write.
      wr(BASE + 32'hC, 4'hF, 32'h1234_5678);
      rd(BASE + 32'hC);
      check("scratch", bus.data_sram_rdata, 32'h1234_5678);
      wr(BASE + 32'hC, 4'b1000, 32'hFFFF_FFFF);
      rd(BASE + 32'hC);
      check("scratch_partial", bus.data_sram_rdata, 32'h1234_5678);

      // Register window writes must not touch RAM word 0.
      wr(32'h0000_0000, 4'hF, 32'h0BAD_F00D);
      wr(BASE + 32'h0, 4'hF, 32'h0000_ABCD);
      rd(32'h0000_0000);
      check("mmio_no_ram", bus.data_sram_rdata, 32'h0BAD_F00D);

      // Switch synchroniser: change sampled at edge 1, visible after edge 2.
      switch_in = 8'h5A;
      rd(BASE + 32'h4);
      check("switch_early", bus.data_sram_rdata, 32'h0);
      idle();
      rd(BASE + 32'h4);
      check("switch_sync", bus.data_sram_rdata, 32'h0000_005A);

      // Reset asserted between a read request and its edge.
      bus.data_sram_en    = 1'b1;
      bus.data_sram_wen   = 4'b0000;
      bus.data_sram_addr  = 32'h0000_0010;
      #2;
      rst = 1'b0;
      #1;
      check("rst_rdata", bus.data_sram_rdata, 32'h0);
      check("rst_led", {16'h0, led_out}, 32'h0);
      @(negedge clk);
      check("rst_read_dropped", bus.data_sram_rdata, 32'h0);
      // A write presented during reset is dropped as well.
      wr(32'h0000_0010, 4'hF, 32'h0000_0000);
      rst = 1'b1;

      // First edge after release: timer 0 -> 1.
      rd(BASE + 32'h8);
      check("timer_after_rst1", bus.data_sram_rdata, 32'h0000_0001);
      rd(BASE + 32'h8);
      check("timer_after_rst2", bus.data_sram_rdata, 32'h0000_0002);
      rd(32'h0000_0010);
      check("ram_kept_over_rst", bus.data_sram_rdata, 32'hA5A5_A5A5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/dsram_responder.md
Name: dsram_responder

Overview:
- Responder end of the core's data SRAM interface. Answers the single-cycle en/wen/addr/wdata request and returns read data one cycle later.
- Contains a byte-writable word RAM and a small memory-mapped register window: LED, switches, free-running timer and scratch.
- Sits outside the CPU core at top level. Drives data_sram_rdata back into the MEM stage.

Parameters:
- ADDR_W, 12, word-index width of backing RAM (2^ADDR_W 32-bit words).
- MMIO_BASE, 32'hBFAF_0000, base of register window; only bits [31:16] are compared.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous active-low reset
- data_sram_en  input  1  access request this cycle
- data_sram_wen  input  4  byte write enables; 4'b0000 with en=1 is a read
- data_sram_addr  input  32  byte address; bits [1:0] ignored
- data_sram_wdata  input  32  write data, lane i = bits [8i+7:8i]
- data_sram_rdata  output  32  registered read data
- switch_in  input  8  asynchronous board switches
- led_out  output  16  LED register value

Behaviour:
- Reset (rst=0, asynchronous): data_sram_rdata=0, led_out=0, timer=0, scratch=0, switch synchronizer flops=0. RAM contents are not reset.
- Reset released mid-access: any request sampled while rst=0 is dropped. rdata stays 0 until the first read after release.
- Decode: MMIO when addr[31:16]==MMIO_BASE[31:16], else RAM.
- RAM index = addr[ADDR_W+1:2]. Upper address bits are ignored, so the RAM aliases modulo 2^(ADDR_W+2) bytes.
- Read (en=1, wen=0): data_sram_rdata updates at the next rising edge. Latency exactly 1 cycle.
- rdata holds its value on cycles with en=0 and on write cycles.
- RAM write (en=1, wen!=0): each byte lane with wen[i]=1 is written at the edge. Other lanes are unchanged.
- A read of the same word in the next cycle returns the new data. No read-during-write hazard exists, because reads and writes are mutually exclusive per cycle.
- en=0: no state change except the timer and the switch synchronizer.
- MMIO map (offset = addr[15:0]):
  - 0x0000 LED: RW. Reads {16'b0, led}. Write loads wdata[15:0].
  - 0x0004 SWITCH: RO. Reads {24'b0, sw_sync}. Writes ignored.
  - 0x0008 TIMER: RW. 32-bit counter, +1 every cycle, wraps 0xFFFFFFFF→0. A write loads wdata, and the write wins over that cycle's increment; counting resumes the following cycle. A read returns the value held at the sampling edge.
  - 0x000C SCRATCH: RW 32-bit.
  - Any other offset reads 0; writes ignored.
- MMIO writes take effect only when wen==4'b1111. Partial-byte MMIO writes are ignored with no side effect.
- switch_in passes through a 2-flop synchronizer. sw_sync reflects a switch change 2 edges after the change is sampled.
- led_out is a direct register output with no extra latency after the write edge.

Test Plan:
- Write 0xDEADBEEF with wen=4'hF to 0x0000_0010, then read 0x0000_0010 → rdata=0xDEADBEEF one cycle after the read edge.
- Byte lanes: after the above, write wdata=0x11223344 with wen=4'b0101 to the same address, then read → 0xDE22BE44.
- Aliasing (ADDR_W=12): write 0xA5A5A5A5 to 0x0000_4010, then read 0x0000_0010 → 0xA5A5A5A5.
- Timer:
  - Write 0xFFFFFFFE to MMIO_BASE+8 → read issued 1 cycle after the write returns 0xFFFFFFFF.
  - Next-cycle read returns 0x00000000 (wrap).
- MMIO misc:
  - LED write 0x0001ABCD with wen=F → led_out=0xABCD.
  - LED write with wen=4'b0011 → led_out unchanged.
  - Read MMIO_BASE+0x0010 → 0.
  - switch_in=8'h5A → SWITCH read returns 0x5A once 2 edges have elapsed.
- Reset mid-op: assert rst=0 between a read request and the following edge → rdata=0 immediately, led_out=0, timer=0. After release, the timer counts up from 0.
